// File: rtl/adder.sv
// Registered unsigned adder: {cout, s} = a + b + cin with one-cycle latency.
// The carries come from a Kogge-Stone prefix tree whose depth grows as log2(WIDTH).

module adder_pc (
  input  logic i_gh,
  input  logic i_ph,
  input  logic i_gl,
  input  logic i_pl,
  output logic o_g,
  output logic o_p
);
  assign o_g = i_gh | (i_ph & i_gl);
  assign o_p = i_ph & i_pl;
endmodule

module adder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  input  logic             clk,
  input  logic             rst
);
  localparam int LVL = (WIDTH > 1) ? $clog2(WIDTH) : 0;

  logic [WIDTH:0]   w_c;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] r_s;
  logic             r_cout;

  // Each level has its own vectors, so no signal appears to feed back into itself.
  for (genvar k = 0; k <= LVL; k++) begin : g_lvl
    logic [WIDTH-1:0] g, p;
    if (k == 0) begin : g_base
      assign g = a & b;
      assign p = a ^ b;
    end else begin : g_tree
      localparam int D = 1 << (k - 1);
      for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        if (i >= D) begin : g_cell
          adder_pc u_pc (
            .i_gh (g_lvl[k-1].g[i]),
            .i_ph (g_lvl[k-1].p[i]),
            .i_gl (g_lvl[k-1].g[i-D]),
            .i_pl (g_lvl[k-1].p[i-D]),
            .o_g  (g[i]),
            .o_p  (p[i])
          );
        end else begin : g_pass
          assign g[i] = g_lvl[k-1].g[i];
          assign p[i] = g_lvl[k-1].p[i];
        end
      end
    end
  end

  // cin acts as the generate of position -1. It folds into every group prefix [i:0].
  assign w_c[0] = cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_carry
    adder_pc u_cin (
      .i_gh (g_lvl[LVL].g[i]),
      .i_ph (g_lvl[LVL].p[i]),
      .i_gl (cin),
      .i_pl (1'b0),
      .o_g  (w_c[i+1]),
      .o_p  ()
    );
  end

  assign w_sum = g_lvl[0].p ^ w_c[WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s    <= '0;
      r_cout <= 1'b0;
    end else begin
      r_s    <= w_sum;
      r_cout <= w_c[WIDTH];
    end
  end

  assign s    = r_s;
  assign cout = r_cout;
endmodule

// File: tb/tb_adder.sv
// Directed checks of the 8-bit adder against hand-computed sums.
// Random a+b+cin runs at WIDTH 8, 1, 5 and 32.

module tb_adder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [7:0]  a8, b8, s8;   logic ci8, co8;
  logic [0:0]  a1, b1, s1;   logic ci1, co1;
  logic [4:0]  a5, b5, s5;   logic ci5, co5;
  logic [31:0] a32, b32, s32; logic ci32, co32;

  adder #(.WIDTH(8))  u_a8  (.a(a8),  .b(b8),  .cin(ci8),  .s(s8),  .cout(co8),  .clk(clk), .rst(rst));
  adder #(.WIDTH(1))  u_a1  (.a(a1),  .b(b1),  .cin(ci1),  .s(s1),  .cout(co1),  .clk(clk), .rst(rst));
  adder #(.WIDTH(5))  u_a5  (.a(a5),  .b(b5),  .cin(ci5),  .s(s5),  .cout(co5),  .clk(clk), .rst(rst));
  adder #(.WIDTH(32)) u_a32 (.a(a32), .b(b32), .cin(ci32), .s(s32), .cout(co32), .clk(clk), .rst(rst));

  int nchk = 0;
  int nerr = 0;

  task automatic chk(input string tag, input logic [32:0] got, input logic [32:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Apply one vector on the next edge, then check the registered result just after it.
  task automatic step8(input string tag, input logic r, input logic [7:0] va, input logic [7:0] vb,
                       input logic vc, input logic [8:0] exp);
    rst = r; a8 = va; b8 = vb; ci8 = vc;
    @(posedge clk); #1;
    chk(tag, {24'd0, co8, s8}, {24'd0, exp});
  endtask

  initial begin
    logic [32:0] e8, e1, e5, e32;
    a1 = '0; b1 = '0; ci1 = 1'b0;
    a5 = '0; b5 = '0; ci5 = 1'b0;
    a32 = '0; b32 = '0; ci32 = 1'b0;

    // Reset holds the outputs at zero even with live operands.
    step8("rst_hold0", 1'b1, 8'd37, 8'd99, 1'b1, 9'd0);
    step8("rst_hold1", 1'b1, 8'd37, 8'd99, 1'b1, 9'd0);
    step8("rst_rel",   1'b0, 8'd37, 8'd99, 1'b1, 9'd137);

    step8("zero",      1'b0, 8'd0,   8'd0,   1'b0, 9'd0);
    step8("wrap_b1",   1'b0, 8'd255, 8'd1,   1'b0, 9'd256);
    step8("ones_ones", 1'b0, 8'd255, 8'd255, 1'b1, 9'd511);
    step8("wrap_cin",  1'b0, 8'd255, 8'd0,   1'b1, 9'd256);

    // Back-to-back stream: one result per edge, no bubbles.
    step8("strm0", 1'b0, 8'd100, 8'd27,  1'b1, 9'd128);
    step8("strm1", 1'b0, 8'd128, 8'd128, 1'b0, 9'd256);
    step8("strm2", 1'b0, 8'd15,  8'd240, 1'b0, 9'd255);

    // A one-cycle reset inside a stream zeros only that slot.
    step8("mid0",   1'b0, 8'd10, 8'd20, 1'b0, 9'd30);
    step8("midrst", 1'b1, 8'd50, 8'd60, 1'b1, 9'd0);
    step8("mid2",   1'b0, 8'd70, 8'd80, 1'b0, 9'd150);
    step8("mid3",   1'b0, 8'd200, 8'd57, 1'b1, 9'd258);

    // Input wiggles between edges must not reach the outputs.
    a8 = 8'd3; b8 = 8'd4; ci8 = 1'b0;
    @(posedge clk); #2;
    a8 = 8'd90; b8 = 8'd90; ci8 = 1'b1;
    #2;
    chk("hold", {24'd0, co8, s8}, 33'd7);
    a8 = 8'd3; b8 = 8'd4; ci8 = 1'b0;
    @(posedge clk); #1;

    // Random runs at every width, checked against a plain integer sum.
    for (int n = 0; n < 1000; n++) begin
      a8  = 8'($urandom);  b8  = 8'($urandom);  ci8  = 1'($urandom);
      a1  = 1'($urandom);  b1  = 1'($urandom);  ci1  = 1'($urandom);
      a5  = 5'($urandom);  b5  = 5'($urandom);  ci5  = 1'($urandom);
      a32 = $urandom;      b32 = $urandom;      ci32 = 1'($urandom);
      e8  = 33'(a8)  + 33'(b8)  + 33'(ci8);
      e1  = 33'(a1)  + 33'(b1)  + 33'(ci1);
      e5  = 33'(a5)  + 33'(b5)  + 33'(ci5);
      e32 = 33'(a32) + 33'(b32) + 33'(ci32);
      @(posedge clk); #1;
      chk("rnd8",  {24'd0, co8, s8},  e8);
      chk("rnd1",  {31'd0, co1, s1},  e1);
      chk("rnd5",  {27'd0, co5, s5},  e5);
      chk("rnd32", {co32, s32},       e32);
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
